regfile_read_sched: RTL

Round-robin scheduler that shares one combinational 32-to-1 × 32-bit read mux (`mux_32_32`, the register-file read port) among four requesters. It arbitrates register-read requests and drives the mux select. It captures the mux output into a registered response with a valid/ready handshake, so the datapath can stall the response. It sits between the register file's read mux and the pipeline/debug/test agents that need register reads.

---
 rtl/regfile_read_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/regfile_read_sched.sv
// regfile_read_sched: shares one 32-to-1 x 32-bit register-file read mux
// among four requesters and returns the read data through a registered
// valid/ready response slot.
// Build option: REGFILE_SCHED_RR_EN selects round-robin arbitration.
// When it is left undefined, arbitration is fixed priority with requester 0
// highest, and the rotating priority pointer does not exist.
module regfile_read_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_addr,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        mux_sel,
  input  logic [W-1:0]      mux_out,
  output logic [W-1:0]      rdata,
  output logic [1:0]        rid,
  output logic              rvalid,
  input  logic              rready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } resp_state_t;

  resp_state_t state, state_next;
  logic        stall;
  logic        found;
  logic        grant_en;
  logic [1:0]  win;
  logic [1:0]  idx;

`ifdef REGFILE_SCHED_RR_EN
  logic [1:0]  ptr;
`endif

  assign rvalid   = (state == FULL);
  assign stall    = rvalid & ~rready;
  assign grant_en = rst_n & found & ~stall;

  // Winner search: first requesting index starting at the priority origin.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef REGFILE_SCHED_RR_EN
      idx = ptr + 2'(k);
`else
      idx = 2'(k);
`endif
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot grant and mux select for the winner; both are zero when idle.
  always_comb begin
    gnt     = '0;
    mux_sel = '0;
    if (grant_en) begin
      gnt[win] = 1'b1;
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (win == 2'(k)) begin
          mux_sel = req_addr[5*k +: 5];
        end
      end
    end
  end

  // Response slot next state: a grant always refills it, a consumed
  // response without a new grant empties it, a stall holds it.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (grant_en) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (grant_en) begin
          state_next = FULL;
        end else if (rready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Response slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Response payload capture from the mux output on a granted edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rid   <= '0;
    end else if (grant_en) begin
      rdata <= mux_out;
      rid   <= win;
    end
  end

`ifdef REGFILE_SCHED_RR_EN
  // Rotating priority pointer: next search starts just past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_en) begin
      ptr <= win + 2'd1;
    end
  end
`endif

endmodule
